// File: rtl/pu_sequencer.sv
// rtl/pu_sequencer.sv - issue/execute/write-back sequencer driving a processing_unit
// Optional PU_SEQ_FLAGS_EN adds registered flag_zero/flag_neg outputs.
module pu_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              instr_li,
  input  logic [OP_W-1:0]   instr_op,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_rs1,
  input  logic [ADDR_W-1:0] instr_rs2,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [ADDR_W-1:0] readreg1,
  output logic [ADDR_W-1:0] readreg2,
  output logic [OP_W-1:0]   alu_ctrl,
  input  logic [DATA_W-1:0] result,
  output logic [ADDR_W-1:0] writereg,
  output logic [DATA_W-1:0] data,
  output logic              regwrite,
  output logic              busy,
  output logic              done,
`ifdef PU_SEQ_FLAGS_EN
  output logic              flag_zero,
  output logic              flag_neg,
`endif
  output logic [DATA_W-1:0] done_value
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rd_q;
  logic                accept;

  assign instr_ready = (state_q == IDLE) && !clr;
  assign accept      = instr_valid && instr_ready;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = instr_li ? WB : EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Every PU-facing output is loaded on the edge entering the state that uses it,
  // so the ALU result only ever reaches the outputs through a flop.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rd_q       <= '0;
      readreg1   <= '0;
      readreg2   <= '0;
      alu_ctrl   <= '0;
      writereg   <= '0;
      data       <= '0;
      done_value <= '0;
      regwrite   <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      regwrite <= 1'b0;
      done     <= 1'b0;
      busy     <= (state_d != IDLE);
      case (state_q)
        IDLE: begin
          if (accept) begin
            rd_q <= instr_rd;
            if (instr_li) begin
              writereg   <= instr_rd;
              data       <= instr_imm;
              done_value <= instr_imm;
              done       <= 1'b1;
              regwrite   <= (instr_rd != '0);
            end else begin
              readreg1 <= instr_rs1;
              readreg2 <= instr_rs2;
              alu_ctrl <= instr_op;
            end
          end
        end
        EXEC: begin
          writereg   <= rd_q;
          data       <= result;
          done_value <= result;
          done       <= 1'b1;
          regwrite   <= (rd_q != '0);
        end
        default: ;
      endcase
    end
  end

`ifdef PU_SEQ_FLAGS_EN
  // data still holds the completed value while in WB
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      flag_zero <= 1'b0;
      flag_neg  <= 1'b0;
    end else if (state_q == WB) begin
      flag_zero <= (data == '0);
      flag_neg  <= data[DATA_W-1];
    end
  end
`endif

endmodule

// File: tb/tb_pu_sequencer.sv
// tb/tb_pu_sequencer.sv - self-checking bench for pu_sequencer with a behavioural PU model
module tb_pu_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic        instr_valid, instr_ready, instr_li;
  logic [2:0]  instr_op;
  logic [4:0]  instr_rd, instr_rs1, instr_rs2;
  logic [31:0] instr_imm;
  logic [4:0]  readreg1, readreg2, writereg;
  logic [2:0]  alu_ctrl;
  logic [31:0] result, data, done_value;
  logic        regwrite, busy, done;
`ifdef PU_SEQ_FLAGS_EN
  logic        flag_zero, flag_neg;
`endif

  pu_sequencer #(.DATA_W(32), .ADDR_W(5), .OP_W(3)) dut (
    .clk(clk), .clr(clr),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_li(instr_li),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1),
    .instr_rs2(instr_rs2), .instr_imm(instr_imm),
    .readreg1(readreg1), .readreg2(readreg2), .alu_ctrl(alu_ctrl),
    .result(result), .writereg(writereg), .data(data), .regwrite(regwrite),
    .busy(busy), .done(done),
`ifdef PU_SEQ_FLAGS_EN
    .flag_zero(flag_zero), .flag_neg(flag_neg),
`endif
    .done_value(done_value)
  );

  always #5 clk = ~clk;

  logic [31:0] pu_rf  [32] = '{default: 32'h0};
  logic [31:0] ref_rf [32] = '{default: 32'h0};
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    alu_f = a + b;
      3'd1:    alu_f = a - b;
      3'd2:    alu_f = a & b;
      3'd3:    alu_f = a | b;
      3'd4:    alu_f = a ^ b;
      3'd5:    alu_f = a << b[4:0];
      3'd6:    alu_f = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: alu_f = b;
    endcase
  endfunction

  // Processing unit: combinational ALU over the register file, write on clock edge
  always_comb result = alu_f(alu_ctrl, pu_rf[readreg1], pu_rf[readreg2]);
  always @(posedge clk) if (regwrite && writereg != 5'd0) pu_rf[writereg] <= data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!instr_ready && k < 10) begin
      step();
      k++;
    end
    chk("ready_timeout", {31'b0, instr_ready}, 32'd1);
  endtask

  task automatic run_instr(input logic li, input logic [2:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] imm, input logic [31:0] exp_val);
    wait_ready();
    instr_valid = 1'b1; instr_li = li; instr_op = op; instr_rd = rd;
    instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
    step();
    instr_valid = 1'b0;
    instr_imm   = ~imm;
    if (!li) begin
      chk("exec_busy", {31'b0, busy}, 32'd1);
      chk("exec_readreg1", {27'b0, readreg1}, {27'b0, rs1});
      chk("exec_readreg2", {27'b0, readreg2}, {27'b0, rs2});
      chk("exec_alu_ctrl", {29'b0, alu_ctrl}, {29'b0, op});
      chk("exec_done", {31'b0, done}, 32'd0);
      chk("exec_regwrite", {31'b0, regwrite}, 32'd0);
      chk("exec_ready", {31'b0, instr_ready}, 32'd0);
      step();
    end
    chk("wb_busy", {31'b0, busy}, 32'd1);
    chk("wb_done", {31'b0, done}, 32'd1);
    chk("wb_regwrite", {31'b0, regwrite}, (rd != 5'd0) ? 32'd1 : 32'd0);
    chk("wb_writereg", {27'b0, writereg}, {27'b0, rd});
    chk("wb_data", data, exp_val);
    chk("wb_done_value", done_value, exp_val);
    chk("wb_ready", {31'b0, instr_ready}, 32'd0);
    step();
    chk("post_done", {31'b0, done}, 32'd0);
    chk("post_regwrite", {31'b0, regwrite}, 32'd0);
    chk("post_busy", {31'b0, busy}, 32'd0);
`ifdef PU_SEQ_FLAGS_EN
    chk("flag_zero", {31'b0, flag_zero}, (exp_val == 32'd0) ? 32'd1 : 32'd0);
    chk("flag_neg", {31'b0, flag_neg}, {31'b0, exp_val[31]});
`endif
    if (rd != 5'd0) ref_rf[rd] = exp_val;
  endtask

  typedef struct {
    logic        li;
    logic [2:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [31:0] exp_val;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int acc, dn, seen;
    tbl[0]  = '{1'b1, 3'd0, 5'd3, 5'd0, 5'd0, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[1]  = '{1'b1, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'd5};
    tbl[2]  = '{1'b1, 3'd0, 5'd2, 5'd0, 5'd0, 32'd7, 32'd7};
    tbl[3]  = '{1'b0, 3'd0, 5'd4, 5'd1, 5'd2, 32'h0, 32'd12};
    tbl[4]  = '{1'b0, 3'd1, 5'd0, 5'd1, 5'd2, 32'h0, 32'hFFFFFFFE};
    tbl[5]  = '{1'b0, 3'd2, 5'd5, 5'd3, 5'd2, 32'h0, 32'd7};
    tbl[6]  = '{1'b0, 3'd4, 5'd6, 5'd1, 5'd2, 32'h0, 32'd2};
    tbl[7]  = '{1'b0, 3'd6, 5'd7, 5'd3, 5'd1, 32'h0, 32'd1};
    tbl[8]  = '{1'b1, 3'd0, 5'd8, 5'd0, 5'd0, 32'h0, 32'h0};
    tbl[9]  = '{1'b1, 3'd0, 5'd9, 5'd0, 5'd0, 32'h80000000, 32'h80000000};
    tbl[10] = '{1'b0, 3'd3, 5'd10, 5'd4, 5'd9, 32'h0, 32'h8000000C};

    clr = 1'b1; instr_valid = 1'b0; instr_li = 1'b0; instr_op = '0;
    instr_rd = '0; instr_rs1 = '0; instr_rs2 = '0; instr_imm = '0;
    step(); step();
    chk("rst_ready", {31'b0, instr_ready}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_regwrite", {31'b0, regwrite}, 32'd0);
    chk("rst_readreg1", {27'b0, readreg1}, 32'd0);
    chk("rst_writereg", {27'b0, writereg}, 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_done_value", done_value, 32'd0);
    clr = 1'b0;
    #1;
    chk("rst_release_ready", {31'b0, instr_ready}, 32'd1);

    for (int i = 0; i < 11; i++)
      run_instr(tbl[i].li, tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, tbl[i].exp_val);

    // instr_valid held high across three load-immediates
    step();
    instr_valid = 1'b1; instr_li = 1'b1; instr_rd = 5'd11; instr_imm = 32'h55;
    acc = 0; dn = 0;
    for (int c = 0; c < 6; c++) begin
      if (instr_ready) acc++;
      step();
      if (done) dn++;
    end
    instr_valid = 1'b0;
    chk("hold_accepts", acc, 32'd3);
    chk("hold_dones", dn, 32'd3);
    ref_rf[11] = 32'h55;

    // clr asserted while an ALU op sits in EXEC
    wait_ready();
    instr_valid = 1'b1; instr_li = 1'b0; instr_op = 3'd0;
    instr_rd = 5'd12; instr_rs1 = 5'd1; instr_rs2 = 5'd2;
    step();
    instr_valid = 1'b0;
    chk("clr_pre_exec_busy", {31'b0, busy}, 32'd1);
    #2 clr = 1'b1;
    #1;
    chk("clr_busy", {31'b0, busy}, 32'd0);
    chk("clr_readreg1", {27'b0, readreg1}, 32'd0);
    chk("clr_alu_ctrl", {29'b0, alu_ctrl}, 32'd0);
    chk("clr_ready", {31'b0, instr_ready}, 32'd0);
    seen = 0;
    for (int c = 0; c < 2; c++) begin
      step();
      if (done || regwrite) seen++;
    end
    chk("clr_no_wb", seen, 32'd0);
    clr = 1'b0;
    #1;
    chk("clr_release_ready", {31'b0, instr_ready}, 32'd1);
    chk("clr_r12_untouched", pu_rf[12], ref_rf[12]);

    for (int n = 0; n < 60; n++) begin
      logic        li;
      logic [2:0]  op;
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] imm, ev;
      li  = ($urandom_range(0, 3) == 0);
      op  = 3'($urandom_range(0, 7));
      rd  = 5'($urandom_range(0, 15));
      rs1 = 5'($urandom_range(0, 15));
      rs2 = 5'($urandom_range(0, 15));
      imm = $urandom;
      ev  = li ? imm : alu_f(op, ref_rf[rs1], ref_rf[rs2]);
      repeat ($urandom_range(0, 2)) step();
      run_instr(li, op, rd, rs1, rs2, imm, ev);
    end

    for (int r = 0; r < 16; r++)
      chk($sformatf("rf_r%0d", r), pu_rf[r], ref_rf[r]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
